// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: buffering bridge between the UART receiver output and the
// UART transmitter input. Received bytes are queued in a FIFO and handed to
// the transmitter one at a time with a request / busy / done handshake.
//
// Build option: define UART_LOOP_CRLF_EN to have a 8'h0A automatically sent
// after every 8'h0D that the transmitter accepted.
//
// Transmit FSM
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | nothing in flight; pop the head when the transmitter is idle
//   ST_PRESENT   | tx_din_rdy high, waiting for the transmitter to go busy
//   ST_WAIT_DONE | transmitter busy, waiting for it to become idle again
//   ST_LF        | (UART_LOOP_CRLF_EN only) load the inserted 8'h0A

module uart_loop_fifo #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int ACK_TIMEOUT = 65535
) (
   input  logic              clk_16MHz,
   input  logic              rst_n,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_byte,
   input  logic              tx_uart_ready,
   input  logic              clr_overflow,
   output logic              tx_din_rdy,
   output logic [7:0]        tx_din_byte,
   output logic [ADDR_W:0]   fifo_count,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              overflow,
   output logic              tx_timeout
);

   localparam int              TMO_W    = $clog2(ACK_TIMEOUT + 1);
   // The counter is loaded at the pop, so a load of N-1 keeps tx_din_rdy
   // high for exactly ACK_TIMEOUT cycles before giving up.
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESENT,
      ST_WAIT_DONE
`ifdef UART_LOOP_CRLF_EN
      , ST_LF
`endif
   } state_t;

   logic                r_rx_s1, r_rx_s2, r_rx_s3;
   logic                r_rdy_s1, r_rdy_s2;
   logic [7:0]          r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [ADDR_W:0]     r_count;
   logic                r_overflow;
   logic                r_timeout;
   logic                r_din_rdy;
   logic [7:0]          r_din_byte;
   logic [TMO_W-1:0]    r_tmo_cnt;
   state_t              r_state, w_state_nxt;

   logic                w_push, w_pop, w_drop, w_wr_en;
   logic                w_empty, w_full;
   logic                w_tmo_load, w_tmo_dec, w_set_timeout;
`ifdef UART_LOOP_CRLF_EN
   logic                w_load_lf;
`endif

   // Two-flop synchronizers for both slow-domain inputs, plus the rx edge flop.
   always_ff @(posedge clk_16MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1  <= 1'b0;
         r_rx_s2  <= 1'b0;
         r_rx_s3  <= 1'b0;
         r_rdy_s1 <= 1'b0;
         r_rdy_s2 <= 1'b0;
      end else begin
         r_rx_s1  <= rx_rdy;
         r_rx_s2  <= r_rx_s1;
         r_rx_s3  <= r_rx_s2;
         r_rdy_s1 <= tx_uart_ready;
         r_rdy_s2 <= r_rdy_s1;
      end
   end

   assign w_push  = r_rx_s2 & ~r_rx_s3;
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   // A full FIFO still accepts the push when a pop frees the slot that cycle.
   assign w_drop  = w_push & w_full & ~w_pop;
   assign w_wr_en = w_push & ~w_drop;

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk_16MHz) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= rx_byte;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk_16MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         if (w_wr_en && !w_pop) begin
            r_count <= r_count + (ADDR_W + 1)'(1);
         end else if (!w_wr_en && w_pop) begin
            r_count <= r_count - (ADDR_W + 1)'(1);
         end
      end
   end

   // Sticky overflow; a drop in the same cycle as the clear keeps it set.
   always_ff @(posedge clk_16MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   // Transmit FSM state register.
   always_ff @(posedge clk_16MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Transmit FSM next-state and control strobes.
   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_tmo_load    = 1'b0;
      w_tmo_dec     = 1'b0;
      w_set_timeout = 1'b0;
`ifdef UART_LOOP_CRLF_EN
      w_load_lf     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (!w_empty && r_rdy_s2) begin
               w_pop       = 1'b1;
               w_tmo_load  = 1'b1;
               w_state_nxt = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (!r_rdy_s2) begin
               w_state_nxt = ST_WAIT_DONE;
            end else if (r_tmo_cnt == '0) begin
               w_set_timeout = 1'b1;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_tmo_dec = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (r_rdy_s2) begin
`ifdef UART_LOOP_CRLF_EN
               // After the LF itself the held byte is 8'h0A, so no repeat.
               if (r_din_byte == 8'h0D) begin
                  w_state_nxt = ST_LF;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
`else
               w_state_nxt = ST_IDLE;
`endif
            end
         end
`ifdef UART_LOOP_CRLF_EN
         ST_LF: begin
            w_load_lf   = 1'b1;
            w_tmo_load  = 1'b1;
            w_state_nxt = ST_PRESENT;
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered transmitter interface, timeout counter and sticky timeout flag.
   always_ff @(posedge clk_16MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_din_rdy  <= 1'b0;
         r_din_byte <= 8'h00;
         r_tmo_cnt  <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_din_rdy <= (w_state_nxt == ST_PRESENT);
         if (w_pop) begin
            r_din_byte <= r_mem[r_rd_ptr];
         end
`ifdef UART_LOOP_CRLF_EN
         else if (w_load_lf) begin
            r_din_byte <= 8'h0A;
         end
`endif
         if (w_tmo_load) begin
            r_tmo_cnt <= TMO_LOAD;
         end else if (w_tmo_dec) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
         end
         if (w_set_timeout) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign tx_din_rdy  = r_din_rdy;
   assign tx_din_byte = r_din_byte;
   assign fifo_count  = r_count;
   assign fifo_empty  = w_empty;
   assign fifo_full   = w_full;
   assign overflow    = r_overflow;
   assign tx_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Bench for uart_loop_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_uart_loop_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int TMO    = 64;

   logic              clk_16MHz = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_rdy = 1'b0;
   logic [7:0]        rx_byte = 8'h00;
   logic              tx_uart_ready = 1'b1;
   logic              clr_overflow = 1'b0;
   logic              tx_din_rdy;
   logic [7:0]        tx_din_byte;
   logic [ADDR_W:0]   fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              overflow;
   logic              tx_timeout;

   int vectors = 0;
   int miscompares = 0;

   bit tx_hold = 1'b0;
   bit tx_ignore = 1'b0;
   int busy_left = 0;
   byte unsigned sent[$];

   uart_loop_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_TIMEOUT(TMO)) dut (
      .clk_16MHz    (clk_16MHz),
      .rst_n        (rst_n),
      .rx_rdy       (rx_rdy),
      .rx_byte      (rx_byte),
      .tx_uart_ready(tx_uart_ready),
      .clr_overflow (clr_overflow),
      .tx_din_rdy   (tx_din_rdy),
      .tx_din_byte  (tx_din_byte),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .overflow     (overflow),
      .tx_timeout   (tx_timeout)
   );

   always #31 clk_16MHz = ~clk_16MHz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transmitter stand-in: goes busy for a while after seeing a request.
   initial begin
      forever begin
         @(negedge clk_16MHz);
         if (tx_hold) begin
            tx_uart_ready = 1'b0;
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_uart_ready = 1'b1;
         end else if (tx_din_rdy && tx_uart_ready && !tx_ignore) begin
            tx_uart_ready = 1'b0;
            busy_left = 6;
         end else begin
            tx_uart_ready = 1'b1;
         end
      end
   end

   // Reference model: a byte queue fed 3 clocks after each rx_rdy rise,
   // drained by each new transmit request, checked every cycle.
   initial begin : model
      byte unsigned mq[$];
      int           mcount, run, slow, cnt_before;
      bit           exp_ovf, exp_tmo, lf_pending, cur_lf;
      bit           h_prev, rdy_prev, rise_rx, push_now, rise_tx, fall_tx, pop_now, drop;
      bit [1:0]     rise_pipe;
      byte unsigned last_byte;
      forever begin
         @(posedge clk_16MHz);
         #1;
         if (!rst_n) begin
            mq.delete();
            mcount = 0; run = 0; slow = 0;
            exp_ovf = 0; exp_tmo = 0; lf_pending = 0; cur_lf = 0;
            h_prev = 0; rdy_prev = 0; rise_pipe = 2'b00; last_byte = 8'h00;
         end else begin
            rise_rx   = rx_rdy && !h_prev;
            push_now  = rise_pipe[1];
            rise_pipe = {rise_pipe[0], rise_rx};
            h_prev    = rx_rdy;
            rise_tx   = tx_din_rdy && !rdy_prev;
            fall_tx   = !tx_din_rdy && rdy_prev;
            rdy_prev  = tx_din_rdy;
            pop_now   = 0;
            drop      = 0;
            cnt_before = mcount;
            if (rise_tx) begin
               sent.push_back(tx_din_byte);
               run = 0;
               if (lf_pending) begin
                  lf_pending = 0;
                  cur_lf = 1;
                  last_byte = 8'h0A;
               end else begin
                  cur_lf = 0;
                  pop_now = 1;
                  chk("request_with_data_queued", mq.size() != 0, 1);
                  if (mq.size() != 0) begin
                     last_byte = mq.pop_front();
                     mcount--;
                  end
               end
            end
            if (tx_din_rdy) begin
               run++;
               chk("present_len_le_timeout", run <= TMO, 1);
            end
            if (fall_tx) begin
               if (run == TMO) begin
                  exp_tmo = 1;
               end
`ifdef UART_LOOP_CRLF_EN
               else if (last_byte == 8'h0D && !cur_lf) begin
                  lf_pending = 1;
               end
`endif
               run = 0;
            end
            if (push_now) begin
               drop = (cnt_before == DEPTH) && !pop_now;
               if (drop) begin
                  exp_ovf = 1;
               end else begin
                  mq.push_back(rx_byte);
                  mcount++;
               end
            end
            if (!drop && clr_overflow) exp_ovf = 0;
            if (tx_din_rdy && !tx_uart_ready) slow++; else slow = 0;
            if (tx_din_rdy) chk("busy_response", slow <= 2, 1);
            chk("fifo_count", fifo_count, mcount);
            chk("fifo_empty", fifo_empty, mcount == 0);
            chk("fifo_full", fifo_full, mcount == DEPTH);
            chk("overflow", overflow, exp_ovf);
            chk("tx_timeout", tx_timeout, exp_tmo);
            chk("tx_din_byte", tx_din_byte, last_byte);
         end
      end
   end

   task automatic push_byte(input byte unsigned b, input bit with_clr);
      @(negedge clk_16MHz); rx_byte = b; rx_rdy = 1'b1;
      @(negedge clk_16MHz);
      @(negedge clk_16MHz); if (with_clr) clr_overflow = 1'b1;
      @(negedge clk_16MHz); clr_overflow = 1'b0; rx_rdy = 1'b0;
      repeat (3) @(negedge clk_16MHz);
   endtask

   task automatic wait_sent(input int n);
      for (int i = 0; i < 3000 && sent.size() < n; i++) @(negedge clk_16MHz);
      chk("sent_count", sent.size(), n);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"},   tx_din_rdy, 0);
      chk({tag, "_byte"},  tx_din_byte, 8'h00);
      chk({tag, "_count"}, fifo_count, 0);
      chk({tag, "_empty"}, fifo_empty, 1);
      chk({tag, "_full"},  fifo_full, 0);
      chk({tag, "_ovf"},   overflow, 0);
      chk({tag, "_tmo"},   tx_timeout, 0);
   endtask

   initial begin
      #(62 * 30000);
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      int base;
      byte unsigned exp_seq[$];

      repeat (3) @(negedge clk_16MHz);
      rst_n = 1'b1;
      @(posedge clk_16MHz); #1;
      chk_reset_vals("reset");

      // Single byte with exact push latency and first request.
      @(negedge clk_16MHz); rx_byte = 8'h41; rx_rdy = 1'b1;
      @(posedge clk_16MHz); #1; chk("lat_edge1", fifo_count, 0);
      @(posedge clk_16MHz); #1; chk("lat_edge2", fifo_count, 0);
      @(posedge clk_16MHz); #1; chk("lat_edge3", fifo_count, 1);
      @(posedge clk_16MHz); #1;
      chk("single_rdy", tx_din_rdy, 1);
      chk("single_byte", tx_din_byte, 8'h41);
      @(negedge clk_16MHz); rx_rdy = 1'b0;
      for (int i = 0; i < 50 && tx_din_rdy; i++) @(posedge clk_16MHz);
      #1; chk("single_rdy_drop", tx_din_rdy, 0);
      repeat (20) @(negedge clk_16MHz);
      chk("single_done_count", fifo_count, 0);
      chk("single_sent", sent[sent.size()-1], 8'h41);

      // Burst into a stalled transmitter, overflow, clear, and order check.
      @(negedge clk_16MHz); tx_hold = 1'b1;
      repeat (4) @(negedge clk_16MHz);
      base = sent.size();
      for (int b = 1; b <= 16; b++) push_byte(8'(b), 1'b0);
      chk("burst_count", fifo_count, 16);
      chk("burst_full", fifo_full, 1);
      push_byte(8'hFF, 1'b0);
      chk("burst_ovf", overflow, 1);
      chk("burst_count_after_drop", fifo_count, 16);
      @(negedge clk_16MHz); clr_overflow = 1'b1;
      @(negedge clk_16MHz); clr_overflow = 1'b0;
      chk("ovf_cleared", overflow, 0);
      push_byte(8'hEE, 1'b1);
      chk("ovf_drop_beats_clear", overflow, 1);
      @(negedge clk_16MHz); tx_hold = 1'b0;
      exp_seq.delete();
      for (int b = 1; b <= 16; b++) begin
         exp_seq.push_back(8'(b));
`ifdef UART_LOOP_CRLF_EN
         if (b == 13) exp_seq.push_back(8'h0A);
`endif
      end
      wait_sent(base + exp_seq.size());
      for (int k = 0; k < exp_seq.size(); k++) chk("burst_order", sent[base + k], exp_seq[k]);
      repeat (20) @(negedge clk_16MHz);
      chk("burst_drained", fifo_empty, 1);
      chk("burst_no_extra", sent.size(), base + exp_seq.size());
      @(negedge clk_16MHz); clr_overflow = 1'b1;
      @(negedge clk_16MHz); clr_overflow = 1'b0;
      chk("ovf_cleared2", overflow, 0);

      // Timeout on an ignored request, then the next byte goes through.
      @(negedge clk_16MHz); tx_ignore = 1'b1;
      base = sent.size();
      fork
         begin : count_present
            int n;
            n = 0;
            for (int i = 0; i < 4 * TMO; i++) begin
               @(posedge clk_16MHz); #1;
               if (tx_din_rdy) n++;
               else if (n > 0) break;
            end
            chk("timeout_len", n, TMO);
            chk("timeout_flag", tx_timeout, 1);
            chk("timeout_rdy", tx_din_rdy, 0);
            tx_ignore = 1'b0;
         end
         begin
            push_byte(8'h55, 1'b0);
            push_byte(8'h66, 1'b0);
         end
      join
      wait_sent(base + 2);
      chk("timeout_first", sent[base], 8'h55);
      chk("timeout_next", sent[base + 1], 8'h66);
      repeat (20) @(negedge clk_16MHz);

      // Reset while a byte is presented and three more are queued.
      @(negedge clk_16MHz); tx_ignore = 1'b1;
      for (int b = 0; b < 4; b++) push_byte(8'hA1 + 8'(b), 1'b0);
      chk("pre_reset_count", fifo_count, 3);
      chk("pre_reset_rdy", tx_din_rdy, 1);
      base = sent.size();
      @(negedge clk_16MHz); rst_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      tx_ignore = 1'b0;
      repeat (3) @(negedge clk_16MHz);
      rst_n = 1'b1;
      repeat (40) @(posedge clk_16MHz);
      #1;
      chk("post_reset_count", fifo_count, 0);
      chk("post_reset_rdy", tx_din_rdy, 0);
      chk("post_reset_no_tx", sent.size(), base);

      // Carriage return handling.
      base = sent.size();
      push_byte(8'h0D, 1'b0);
      push_byte(8'h42, 1'b0);
      exp_seq.delete();
      exp_seq.push_back(8'h0D);
`ifdef UART_LOOP_CRLF_EN
      exp_seq.push_back(8'h0A);
`endif
      exp_seq.push_back(8'h42);
      wait_sent(base + exp_seq.size());
      for (int k = 0; k < exp_seq.size(); k++) chk("cr_seq", sent[base + k], exp_seq[k]);
      repeat (40) @(negedge clk_16MHz);
      chk("cr_no_extra", sent.size(), base + exp_seq.size());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
